// File: rtl/divider.sv
// Multi-cycle 32-bit radix-2 restoring divider (signed DIV / unsigned DIVU) for the EX stage.
// Returns quotient on result_lo and remainder on result_hi; stalls the pipeline while busy.
`ifndef FUNCT_BUS
`define FUNCT_BUS 5:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef FUNCT_DIV
`define FUNCT_DIV 6'b011010
`endif
`ifndef FUNCT_DIVU
`define FUNCT_DIVU 6'b011011
`endif

module divider (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [`FUNCT_BUS] funct,
  input  logic             div_en,
  input  logic             flush,
  input  logic [`DATA_BUS]  operand_1,
  input  logic [`DATA_BUS]  operand_2,
  output logic             stall_req,
  output logic             done,
  output logic [`DATA_BUS]  result_hi,
  output logic [`DATA_BUS]  result_lo
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        done_q;
  logic [31:0] res_hi_q;
  logic [31:0] res_lo_q;

  logic        start;
  logic        is_signed;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [33:0] trial;
  logic [31:0] rem_d;
  logic [31:0] quo_d;

  always_comb begin
    is_signed = (funct == `FUNCT_DIV);
    start     = (state_q == IDLE) && div_en && !flush &&
                ((funct == `FUNCT_DIV) || (funct == `FUNCT_DIVU));
    stall_req = rst_n && !flush && (start || (state_q == CALC));
    neg_a     = is_signed && operand_1[31];
    neg_b     = is_signed && operand_2[31];
    mag_a     = neg_a ? (32'd0 - operand_1) : operand_1;
    mag_b     = neg_b ? (32'd0 - operand_2) : operand_2;
    // Shift in the next dividend bit and try subtracting the divisor; a borrow restores.
    trial     = {1'b0, rem_q, quo_q[31]} - {2'b00, dvs_q};
    if (trial[33]) begin
      rem_d = {rem_q[30:0], quo_q[31]};
      quo_d = {quo_q[30:0], 1'b0};
    end else begin
      rem_d = trial[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
    end else if (flush) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q   <= 1'b0;
          res_hi_q <= '0;
          res_lo_q <= '0;
          if (start) begin
            state_q <= CALC;
            dvs_q   <= mag_b;
            // A zero divisor skips the iterations: preload the fixed result and
            // jump the counter straight to the final (sign-fix) cycle.
            if (operand_2 == 32'd0) begin
              quo_q     <= '1;
              rem_q     <= operand_1;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              cnt_q     <= 6'd32;
            end else begin
              quo_q     <= mag_a;
              rem_q     <= '0;
              neg_quo_q <= neg_a ^ neg_b;
              neg_rem_q <= neg_a;
              cnt_q     <= '0;
            end
          end
        end
        CALC: begin
          if (cnt_q == 6'd32) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            res_lo_q <= neg_quo_q ? (32'd0 - quo_q) : quo_q;
            res_hi_q <= neg_rem_q ? (32'd0 - rem_q) : rem_q;
          end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          done_q   <= 1'b0;
          res_hi_q <= '0;
          res_lo_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;

endmodule
